// File: rtl/vending_pkg.sv
// Shared vending definitions: cent width, coin values and the credit FSM state encoding.
package vending_pkg;

    localparam int CENT_W = 9;
    localparam int COIN_W = 7;

    localparam logic [COIN_W-1:0] NICKEL_C  = 7'd5;
    localparam logic [COIN_W-1:0] DIME_C    = 7'd10;
    localparam logic [COIN_W-1:0] QUARTER_C = 7'd25;
    localparam logic [COIN_W-1:0] DOLLAR_C  = 7'd100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

endpackage

// File: rtl/coin_credit_accum_if.sv
// Change hand-off channel between the credit accumulator and the coin dispenser.
interface coin_credit_accum_if;
    import vending_pkg::*;

    logic [CENT_W-1:0] change_amt;
    logic              change_valid;
    logic              change_ack;

    modport master (output change_amt, output change_valid, input change_ack);
    modport slave  (input change_amt, input change_valid, output change_ack);

endinterface

// File: rtl/coin_decode.sv
// Combinational coin decoder: one pulse gives a value, several pulses flag multi.
module coin_decode
    import vending_pkg::*;
(
    input  logic              nickel,
    input  logic              dime,
    input  logic              quarter,
    input  logic              dollar,
    output logic              valid,
    output logic [COIN_W-1:0] value,
    output logic              multi
);

    // Decode the one-hot pulse set; any other non-zero pattern is a multi-coin event.
    always_comb begin
        valid = 1'b0;
        value = 7'd0;
        multi = 1'b0;
        case ({dollar, quarter, dime, nickel})
            4'b0000: begin
                valid = 1'b0;
            end
            4'b0001: begin
                valid = 1'b1;
                value = NICKEL_C;
            end
            4'b0010: begin
                valid = 1'b1;
                value = DIME_C;
            end
            4'b0100: begin
                valid = 1'b1;
                value = QUARTER_C;
            end
            4'b1000: begin
                valid = 1'b1;
                value = DOLLAR_C;
            end
            default: begin
                multi = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/coin_credit_accum.sv
// Coin credit accumulator with buy/cancel and a valid/ack change output.
// Optional idle auto-cancel is built when COIN_TIMEOUT_EN is defined.
module coin_credit_accum
    import vending_pkg::*;
#(
    parameter int MAX_CREDIT     = 500
`ifdef COIN_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 50_000_000
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_nickel,
    input  logic                coin_dime,
    input  logic                coin_quarter,
    input  logic                coin_dollar,
    input  logic                buy,
    input  logic [CENT_W-1:0]   price,
    input  logic                cancel,
    output logic [CENT_W-1:0]   credit,
    output logic                coin_reject,
    output logic                short_funds,
    output logic                vend,
    coin_credit_accum_if.master chg
);

    localparam logic [CENT_W:0] MAX_SUM = (CENT_W + 1)'(MAX_CREDIT);

    state_t              state_r, state_n;
    logic [CENT_W-1:0]   credit_r, credit_n;
    logic [CENT_W-1:0]   amt_r, amt_n;
    logic                cv_r, cv_n;
    logic                vend_r, vend_n;
    logic                rej_r, rej_n;
    logic                sf_r, sf_n;

    logic                coin_valid_s;
    logic                coin_multi_s;
    logic [COIN_W-1:0]   coin_value_s;
    logic                any_coin_s;
    logic [CENT_W:0]     sum_s;
    logic                timeout_s;
    logic                cancel_take_s;

    coin_decode u_coin_decode (
        .nickel  (coin_nickel),
        .dime    (coin_dime),
        .quarter (coin_quarter),
        .dollar  (coin_dollar),
        .valid   (coin_valid_s),
        .value   (coin_value_s),
        .multi   (coin_multi_s)
    );

    assign any_coin_s = coin_valid_s | coin_multi_s;
    // One extra bit so a near-ceiling credit plus a dollar cannot wrap.
    assign sum_s      = {1'b0, credit_r} + {3'b000, coin_value_s};

`ifdef COIN_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMR_W-1:0] timer_r;
    logic             quiet_s;

    assign quiet_s   = (state_r == COLLECT) && !any_coin_s && !buy && !cancel;
    assign timeout_s = quiet_s && (timer_r == TMR_W'(TIMEOUT_CYCLES - 1));

    // Idle counter: runs only on quiet COLLECT cycles, restarts on any activity or exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= '0;
        end else if (quiet_s && !timeout_s) begin
            timer_r <= timer_r + 1'b1;
        end else begin
            timer_r <= '0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    assign cancel_take_s = (cancel | timeout_s) & (state_r == COLLECT);

    // Next-state and registered-output logic; priority is cancel, then buy, then coin.
    always_comb begin
        state_n  = state_r;
        credit_n = credit_r;
        amt_n    = amt_r;
        cv_n     = cv_r;
        vend_n   = 1'b0;
        rej_n    = 1'b0;
        sf_n     = 1'b0;
        case (state_r)
            IDLE, COLLECT: begin
                if (cancel_take_s) begin
                    amt_n    = credit_r;
                    credit_n = '0;
                    cv_n     = 1'b1;
                    state_n  = CHANGE;
                    rej_n    = any_coin_s;
                end else if (buy) begin
                    if ((price != 9'd0) && (credit_r >= price)) begin
                        state_n  = VEND;
                        vend_n   = 1'b1;
                        amt_n    = credit_r - price;
                        credit_n = '0;
                    end else begin
                        sf_n = 1'b1;
                    end
                    rej_n = any_coin_s;
                end else if (cancel) begin
                    rej_n = any_coin_s;
                end else if (coin_multi_s) begin
                    rej_n = 1'b1;
                end else if (coin_valid_s) begin
                    if (sum_s <= MAX_SUM) begin
                        credit_n = sum_s[CENT_W-1:0];
                        state_n  = COLLECT;
                    end else begin
                        rej_n = 1'b1;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            VEND: begin
                rej_n = any_coin_s;
                // Exact payment skips the change hand-off entirely.
                if (amt_r != 9'd0) begin
                    cv_n    = 1'b1;
                    state_n = CHANGE;
                end else begin
                    state_n = IDLE;
                end
            end
            CHANGE: begin
                rej_n = any_coin_s;
                if (chg.change_ack) begin
                    cv_n    = 1'b0;
                    amt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cv_n = 1'b1;
                end
            end
            default: begin
                state_n  = IDLE;
                credit_n = '0;
                amt_n    = '0;
                cv_n     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            credit_r <= '0;
            amt_r    <= '0;
            cv_r     <= 1'b0;
            vend_r   <= 1'b0;
            rej_r    <= 1'b0;
            sf_r     <= 1'b0;
        end else begin
            state_r  <= state_n;
            credit_r <= credit_n;
            amt_r    <= amt_n;
            cv_r     <= cv_n;
            vend_r   <= vend_n;
            rej_r    <= rej_n;
            sf_r     <= sf_n;
        end
    end

    assign credit           = credit_r;
    assign coin_reject      = rej_r;
    assign short_funds      = sf_r;
    assign vend             = vend_r;
    assign chg.change_amt   = amt_r;
    assign chg.change_valid = cv_r;

endmodule

// File: tb/tb_coin_credit_accum.sv
// Self-checking bench for coin_credit_accum: directed scenarios plus random traffic vs a cents-level model.
module tb_coin_credit_accum;

    localparam int MAXC = 500;
    localparam int TMO  = 8;
    localparam int M_IDLE = 0, M_COLLECT = 1, M_VEND = 2, M_CHANGE = 3;

    logic       clk;
    logic       rst;
    logic       coin_nickel, coin_dime, coin_quarter, coin_dollar;
    logic       buy, cancel;
    logic [8:0] price;
    logic [8:0] credit;
    logic       coin_reject, short_funds, vend;

    coin_credit_accum_if chg_if ();

    coin_credit_accum #(
        .MAX_CREDIT     (MAXC)
`ifdef COIN_TIMEOUT_EN
       ,.TIMEOUT_CYCLES (TMO)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_nickel  (coin_nickel),
        .coin_dime    (coin_dime),
        .coin_quarter (coin_quarter),
        .coin_dollar  (coin_dollar),
        .buy          (buy),
        .price        (price),
        .cancel       (cancel),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .short_funds  (short_funds),
        .vend         (vend),
        .chg          (chg_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model, in cents and abstract modes
    int m_mode = M_IDLE;
    int m_credit = 0;
    int m_change = 0;
    int m_idle = 0;
    bit m_cv = 1'b0, m_rej = 1'b0, m_sf = 1'b0, m_vend = 1'b0;

    logic [21:0] obs, expv;
    assign obs = {credit, coin_reject, short_funds, vend, chg_if.change_amt, chg_if.change_valid};
    always_comb begin
        expv = {m_credit[8:0], m_rej, m_sf, m_vend, m_change[8:0], m_cv};
    end

    // One clock: drive inputs at negedge, advance the model, sample just after posedge.
    task automatic step(input logic [3:0] c, input logic b, input int p,
                        input logic cn, input logic a, input logic r);
        int n, val;
        bit tmo, quiet;
        @(negedge clk);
        {coin_dollar, coin_quarter, coin_dime, coin_nickel} = c;
        buy = b; price = p[8:0]; cancel = cn; chg_if.change_ack = a; rst = r;
        n   = $countones(c);
        val = c[0] ? 5 : c[1] ? 10 : c[2] ? 25 : 100;
        m_rej = 1'b0; m_sf = 1'b0; m_vend = 1'b0;
        tmo = 1'b0;
        quiet = (m_mode == M_COLLECT) && (n == 0) && !b && !cn;
`ifdef COIN_TIMEOUT_EN
        if (quiet && m_idle == TMO - 1) tmo = 1'b1;
`endif
        m_idle = (quiet && !tmo) ? m_idle + 1 : 0;
        if (r) begin
            m_mode = M_IDLE; m_credit = 0; m_change = 0; m_cv = 1'b0; m_idle = 0;
        end else if (m_mode == M_IDLE || m_mode == M_COLLECT) begin
            if ((cn || tmo) && m_mode == M_COLLECT) begin
                m_change = m_credit; m_credit = 0; m_cv = 1'b1; m_mode = M_CHANGE; m_rej = (n > 0);
            end else if (b) begin
                if (p != 0 && m_credit >= p) begin
                    m_vend = 1'b1; m_change = m_credit - p; m_credit = 0; m_mode = M_VEND;
                end else begin
                    m_sf = 1'b1;
                end
                m_rej = (n > 0);
            end else if (cn) begin
                m_rej = (n > 0);
            end else if (n > 1) begin
                m_rej = 1'b1;
            end else if (n == 1) begin
                if (m_credit + val <= MAXC) begin
                    m_credit = m_credit + val; m_mode = M_COLLECT;
                end else begin
                    m_rej = 1'b1;
                end
            end
        end else if (m_mode == M_VEND) begin
            m_rej = (n > 0);
            if (m_change > 0) begin m_cv = 1'b1; m_mode = M_CHANGE; end
            else m_mode = M_IDLE;
        end else begin
            m_rej = (n > 0);
            if (a) begin m_cv = 1'b0; m_change = 0; m_mode = M_IDLE; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b0000, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL reset_state observed=%h required=%h", obs, 22'd0);
        end
    endtask

    task automatic test_purchase();
        logic [3:0] seq [3];
        int want [3];
        seq[0] = 4'b0100; seq[1] = 4'b0100; seq[2] = 4'b0010;
        want[0] = 25; want[1] = 50; want[2] = 60;
        step(4'b0000, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(seq[i], 0, 0, 0, 0, 0);
            checks++;
            if (credit !== want[i][8:0] || obs !== expv) begin
                errors++; $display("FAIL purchase_credit observed=%0d required=%0d", credit, want[i]);
            end
        end
        step(4'b0000, 1, 50, 0, 0, 0);
        checks++;
        if (vend !== 1'b1 || credit !== 9'd0 || obs !== expv) begin
            errors++; $display("FAIL purchase_vend observed=%h required=%h", obs, expv);
        end
        for (int i = 0; i < 6; i++) begin
            step(4'b0000, 0, 0, 0, 0, 0);
            checks++;
            if (chg_if.change_valid !== 1'b1 || chg_if.change_amt !== 9'd10 || vend !== 1'b0 || obs !== expv) begin
                errors++; $display("FAIL purchase_change_hold cycle=%0d observed=%h required=%h", i, obs, expv);
            end
        end
        step(4'b0000, 0, 0, 0, 1, 0);
        checks++;
        if (chg_if.change_valid !== 1'b0 || credit !== 9'd0 || obs !== expv) begin
            errors++; $display("FAIL purchase_ack observed=%h required=%h", obs, expv);
        end
    endtask

    task automatic test_ceiling();
        step(4'b0000, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(4'b1000, 0, 0, 0, 0, 0);
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL ceiling_fill observed=%h required=%h", obs, expv);
            end
        end
        checks++;
        if (credit !== 9'd500) begin
            errors++; $display("FAIL ceiling_500 observed=%0d required=500", credit);
        end
        step(4'b1000, 0, 0, 0, 0, 0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 9'd500 || obs !== expv) begin
            errors++; $display("FAIL ceiling_dollar observed=%h required=%h", obs, expv);
        end
        step(4'b0001, 0, 0, 0, 0, 0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 9'd500 || obs !== expv) begin
            errors++; $display("FAIL ceiling_nickel observed=%h required=%h", obs, expv);
        end
    endtask

    task automatic test_short_funds();
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b0100, 0, 0, 0, 0, 0);
        step(4'b0010, 0, 0, 0, 0, 0);
        step(4'b0000, 1, 75, 0, 0, 0);
        checks++;
        if (short_funds !== 1'b1 || credit !== 9'd35 || vend !== 1'b0 || obs !== expv) begin
            errors++; $display("FAIL short_price75 observed=%h required=%h", obs, expv);
        end
        step(4'b0000, 0, 0, 0, 0, 0);
        checks++;
        if (short_funds !== 1'b0 || obs !== expv) begin
            errors++; $display("FAIL short_one_cycle observed=%b required=0", short_funds);
        end
        step(4'b0000, 1, 0, 0, 0, 0);
        checks++;
        if (short_funds !== 1'b1 || credit !== 9'd35 || obs !== expv) begin
            errors++; $display("FAIL short_price0 observed=%h required=%h", obs, expv);
        end
        step(4'b0001, 0, 0, 0, 0, 0);
        checks++;
        if (credit !== 9'd40 || obs !== expv) begin
            errors++; $display("FAIL short_still_collect observed=%0d required=40", credit);
        end
    endtask

    task automatic test_exact_pay();
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b1000, 0, 0, 0, 0, 0);
        step(4'b0000, 1, 100, 0, 0, 0);
        checks++;
        if (vend !== 1'b1 || credit !== 9'd0 || obs !== expv) begin
            errors++; $display("FAIL exact_vend observed=%h required=%h", obs, expv);
        end
        step(4'b0000, 0, 0, 0, 0, 0);
        checks++;
        if (chg_if.change_valid !== 1'b0 || vend !== 1'b0 || obs !== expv) begin
            errors++; $display("FAIL exact_no_change observed=%h required=%h", obs, expv);
        end
        step(4'b0001, 0, 0, 0, 0, 0);
        checks++;
        if (credit !== 9'd5 || coin_reject !== 1'b0 || obs !== expv) begin
            errors++; $display("FAIL exact_back_idle observed=%h required=%h", obs, expv);
        end
    endtask

    task automatic test_cancel_coin();
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b0100, 0, 0, 0, 0, 0);
        step(4'b0010, 0, 0, 0, 0, 0);
        step(4'b0001, 0, 0, 0, 0, 0);
        step(4'b0010, 0, 0, 1, 0, 0);
        checks++;
        if (coin_reject !== 1'b1 || chg_if.change_valid !== 1'b1 || chg_if.change_amt !== 9'd40 ||
            credit !== 9'd0 || obs !== expv) begin
            errors++; $display("FAIL cancel_with_dime observed=%h required=%h", obs, expv);
        end
        step(4'b0000, 0, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);
        checks++;
        if (chg_if.change_valid !== 1'b0 || credit !== 9'd0 || obs !== expv) begin
            errors++; $display("FAIL cancel_reset_in_change observed=%h required=%h", obs, expv);
        end
    endtask

    task automatic test_multi_coin();
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b0110, 0, 0, 0, 0, 0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 9'd0 || obs !== expv) begin
            errors++; $display("FAIL multi_idle observed=%h required=%h", obs, expv);
        end
        step(4'b0001, 0, 0, 0, 0, 0);
        step(4'b1111, 0, 0, 0, 0, 0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 9'd5 || obs !== expv) begin
            errors++; $display("FAIL multi_collect observed=%h required=%h", obs, expv);
        end
    endtask

    task automatic test_idle_credit();
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b0001, 0, 0, 0, 0, 0);
        for (int i = 0; i < TMO; i++) begin
            step(4'b0000, 0, 0, 0, 0, 0);
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL idle_track cycle=%0d observed=%h required=%h", i, obs, expv);
            end
        end
`ifdef COIN_TIMEOUT_EN
        checks++;
        if (chg_if.change_valid !== 1'b1 || chg_if.change_amt !== 9'd5 || credit !== 9'd0) begin
            errors++; $display("FAIL timeout_cancel observed=%h", obs);
        end
`else
        checks++;
        if (chg_if.change_valid !== 1'b0 || credit !== 9'd5) begin
            errors++; $display("FAIL credit_held observed=%h", obs);
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic b, cn, a, r;
        int p, sel;
        step(4'b0000, 0, 0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 30)      c = 4'b0001 << $urandom_range(0, 3);
            else if (sel < 35) c = 4'($urandom_range(0, 15));
            else               c = 4'b0000;
            b  = ($urandom_range(0, 99) < 10);
            p  = $urandom_range(0, 200);
            cn = ($urandom_range(0, 99) < 5);
            a  = ($urandom_range(0, 99) < 35);
            r  = ($urandom_range(0, 199) == 0);
            step(c, b, p, cn, a, r);
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL random cycle=%0d observed=%h required=%h", i, obs, expv);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        {coin_dollar, coin_quarter, coin_dime, coin_nickel} = 4'b0000;
        buy = 1'b0; cancel = 1'b0; price = 9'd0; chg_if.change_ack = 1'b0;
        test_reset();
        test_purchase();
        test_ceiling();
        test_short_funds();
        test_exact_pay();
        test_cancel_coin();
        test_multi_coin();
        test_idle_credit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coin_credit_accum.md
Name: coin_credit_accum

Overview:
Upstream of the change-to-coins converter. Accumulates inserted coins into a 9-bit cent credit, checks a selected item price on a buy request, and pulses a vend strobe. It then presents the remaining change (credit - price, or the full credit on cancel) as a 9-bit cent amount, held under a valid/ack handshake. The converter consumes change_amt combinationally; the dispenser returns change_ack.

Parameters:
MAX_CREDIT, 500, credit ceiling in cents; coin rejected if credit + coin > MAX_CREDIT (must be <= 511)
TIMEOUT_CYCLES, 50_000_000, idle cycles before auto-cancel (used only with COIN_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
coin_nickel  in  1  single-cycle pulse, 5c inserted (pre-debounced)
coin_dime  in  1  single-cycle pulse, 10c
coin_quarter  in  1  single-cycle pulse, 25c
coin_dollar  in  1  single-cycle pulse, 100c
buy  in  1  single-cycle purchase request
price  in  9  item price in cents, sampled when buy=1
cancel  in  1  single-cycle refund request
change_ack  in  1  downstream has consumed change_amt
credit  out  9  current accumulated credit, cents
coin_reject  out  1  one-cycle pulse: coin refused
short_funds  out  1  one-cycle pulse: buy refused
vend  out  1  one-cycle dispense strobe
change_amt  out  9  change in cents, stable while change_valid=1
change_valid  out  1  change_amt valid, held until change_ack

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE. credit, change_amt, change_valid, vend, coin_reject and short_funds are all 0. A reset mid-vend or mid-change drops change_valid with no ack required.
- States:
  - IDLE: credit=0.
  - COLLECT: credit>0.
  - VEND: one cycle.
  - CHANGE: waiting for ack.
- Coin decode: exactly one coin pulse in a cycle is accepted.
  - More than one coin pulse in the same cycle rejects all of them; coin_reject pulses once.
  - Any coin while in VEND or CHANGE is rejected.
- Accept rule: in IDLE or COLLECT, accept if credit + value <= MAX_CREDIT.
  - Accepted: credit updates the next cycle and the state moves to COLLECT.
  - Refused: coin_reject=1 the next cycle and credit is unchanged.
- Width rule: the credit + value sum is computed 10 bits wide, so no wrap-around occurs.
- Buy (IDLE or COLLECT): if price != 0 and credit >= price, move to VEND.
  - Cycle t+1: vend=1, change_amt <= credit - price, credit <= 0.
  - Cycle t+2: state=CHANGE, change_valid=1.
  - If price=0 or credit < price: short_funds=1 at t+1, no state change.
- Exact payment (change 0): VEND returns directly to IDLE and change_valid is never asserted.
- Cancel (COLLECT): change_amt <= credit, credit <= 0, change_valid=1 at t+1, state=CHANGE. Cancel in IDLE is ignored.
- CHANGE: change_amt and change_valid are held until change_ack=1.
  - change_valid falls in the cycle after ack; the state returns to IDLE.
  - change_ack while change_valid=0 is ignored.
- Simultaneous events in one cycle, priority: cancel > buy > coin.
  - A coin arriving with buy or cancel is rejected (coin_reject pulses).
- Latency: coin->credit is 1 cycle; buy->vend is 1 cycle; vend->change_valid is 1 cycle.

Optional Feature:
COIN_TIMEOUT_EN:
- Defined: a counter counts cycles in COLLECT with no coin, buy or cancel and restarts on any of them. On reaching TIMEOUT_CYCLES-1 it acts as an internal cancel: same timing, change_amt=credit. The counter is cleared by rst and by leaving COLLECT.
- Undefined: no counter is present, and credit is held indefinitely.

Decomposition:
- Shared package vending_pkg:
  - Coin value constants NICKEL_C=5, DIME_C=10, QUARTER_C=25, DOLLAR_C=100.
  - Cent width CENT_W=9.
  - State encoding IDLE/COLLECT/VEND/CHANGE.
- Sub-module coin_decode: combinational. Maps the four pulses to {valid, value[6:0], multi} and is reusable by the coin-return logic.

Test Plan:
- Insert quarter, quarter, dime; buy price=50 -> credit 25, 50, 60; vend at buy+1; change_valid at buy+2 with change_amt=10; held 5 cycles until change_ack, then IDLE with credit=0.
- Five dollar pulses -> credit 500; sixth dollar -> coin_reject=1, credit stays 500; then nickel -> coin_reject=1.
- Credit 35, buy price=75 -> short_funds=1 for one cycle, credit 35, state COLLECT; buy price=0 -> short_funds=1.
- Credit 100, buy price=100 -> vend=1, no change_valid, IDLE next cycle.
- Credit 40, cancel and dime in the same cycle -> coin_reject=1, change_amt=40, change_valid=1; rst asserted while in CHANGE -> change_valid=0, credit=0 the next cycle.
- Quarter and dime pulsed together -> coin_reject=1, credit unchanged. With COIN_TIMEOUT_EN and TIMEOUT_CYCLES=8: credit 5, idle 8 cycles -> change_valid=1, change_amt=5.
